// File: rtl/atd_pkg.sv
// -----------------------------------------------------------------------------
// atd_pkg
// Shared definitions for the ATD serial receive path: the receiver state
// encoding and the default frame/timeout sizing used by atd_rx_controller.
// -----------------------------------------------------------------------------
package atd_pkg;

  localparam int NUM_DATA_BITS  = 8;
  localparam int TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } atd_state_t;

endpackage

// File: rtl/flex_counter.sv
// -----------------------------------------------------------------------------
// flex_counter
// Up-counter with synchronous clear, count enable and a programmable
// rollover value.
//
// Ports
//   clk           system clock (rising edge)
//   n_rst         asynchronous active-low reset
//   clear         synchronous clear to 0, wins over count_enable
//   count_enable  advance the count by one this cycle
//   rollover_val  terminal count; the counter wraps to 0 after it
//   rollover_flag high in the cycle whose clock edge brings the count up to
//                 rollover_val (lets the user react on that same edge)
// -----------------------------------------------------------------------------
module flex_counter #(
  parameter int NUM_CNT_BITS = 8
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] count;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_enable) begin
      if (count == rollover_val) begin
        count <= '0;
      end else begin
        count <= count + NUM_CNT_BITS'(1);
      end
    end
  end

  // Look-ahead: flags the increment that lands on rollover_val.
  assign rollover_flag = count_enable && !clear &&
                         (count == (rollover_val - NUM_CNT_BITS'(1)));

endmodule

// File: rtl/atd_rx_controller.sv
// -----------------------------------------------------------------------------
// atd_rx_controller
// Receives ATD frames (start 0, NUM_DATA_BITS data bits MSB first, stop 1),
// sampling ATD_data only on ATD_shift_enable pulses, and hands complete bytes
// to a consumer through a one-entry valid/ready buffer.
//
// Ports
//   clk, n_rst        clock, asynchronous active-low reset
//   ATD_shift_enable  one-cycle pulse per ATD_clk rising edge
//   ATD_data          synchronized serial data, idles high
//   rx_ready          consumer takes rx_data this cycle
//   clear_errors      clears the sticky overrun_error
//   rx_data           last accepted byte
//   rx_valid          rx_data holds an unconsumed byte
//   busy              receiver is inside a frame
//   framing_error     one-cycle pulse: stop bit sampled low
//   timeout_error     one-cycle pulse: too long between shift pulses
//   overrun_error     sticky: a frame completed while the buffer was full
// -----------------------------------------------------------------------------
module atd_rx_controller #(
  parameter int NUM_DATA_BITS  = atd_pkg::NUM_DATA_BITS,
  parameter int TIMEOUT_CYCLES = atd_pkg::TIMEOUT_CYCLES
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     ATD_shift_enable,
  input  logic                     ATD_data,
  input  logic                     rx_ready,
  input  logic                     clear_errors,
  output logic [NUM_DATA_BITS-1:0] rx_data,
  output logic                     rx_valid,
  output logic                     busy,
  output logic                     framing_error,
  output logic                     timeout_error,
  output logic                     overrun_error
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BIT_W = $clog2(NUM_DATA_BITS + 1);
  localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(NUM_DATA_BITS - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  atd_pkg::atd_state_t      state;
  logic [NUM_DATA_BITS-1:0] shift_reg;
  logic [BIT_W-1:0]         bit_cnt;

  logic timer_clear;
  logic timer_en;
  logic timeout_hit;
  logic stop_pulse;
  logic frame_ok;
  logic frame_bad;

  // Timer held at 0 while idle and restarted by every shift pulse; because a
  // pulse clears it, a pulse arriving on the timeout cycle suppresses the
  // timeout and is sampled normally.
  assign timer_en    = (state != atd_pkg::IDLE);
  assign timer_clear = (state == atd_pkg::IDLE) || ATD_shift_enable;

  flex_counter #(
    .NUM_CNT_BITS (CNT_W)
  ) u_timer (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (timer_clear),
    .count_enable  (timer_en),
    .rollover_val  (TIMEOUT_VAL),
    .rollover_flag (timeout_hit)
  );

  assign stop_pulse = (state == atd_pkg::STOP) && ATD_shift_enable;
  assign frame_ok   = stop_pulse && ATD_data;
  assign frame_bad  = stop_pulse && !ATD_data;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= atd_pkg::IDLE;
      shift_reg     <= '0;
      bit_cnt       <= '0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      busy          <= 1'b0;
      framing_error <= 1'b0;
      timeout_error <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      framing_error <= frame_bad;
      timeout_error <= timeout_hit;

      case (state)
        atd_pkg::IDLE: begin
          if (ATD_shift_enable && !ATD_data) begin
            state   <= atd_pkg::DATA;
            bit_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        atd_pkg::DATA: begin
          if (timeout_hit) begin
            state <= atd_pkg::IDLE;
            busy  <= 1'b0;
          end else if (ATD_shift_enable) begin
            shift_reg <= {shift_reg[NUM_DATA_BITS-2:0], ATD_data};
            bit_cnt   <= bit_cnt + BIT_W'(1);
            if (bit_cnt == LAST_BIT) begin
              state <= atd_pkg::STOP;
            end
          end
        end
        atd_pkg::STOP: begin
          // Stop pulse (good or bad) or timeout both end the frame.
          if (ATD_shift_enable || timeout_hit) begin
            state <= atd_pkg::IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= atd_pkg::IDLE;
          busy  <= 1'b0;
        end
      endcase

      // One-entry output buffer: a completing frame may refill the buffer in
      // the same cycle the consumer drains it; otherwise a full buffer keeps
      // the old byte and the new one is dropped.
      if (frame_ok && (!rx_valid || rx_ready)) begin
        rx_data  <= shift_reg;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      // A new overrun beats a simultaneous clear.
      if (frame_ok && rx_valid && !rx_ready) begin
        overrun_error <= 1'b1;
      end else if (clear_errors) begin
        overrun_error <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_atd_rx_controller.sv
// -----------------------------------------------------------------------------
// tb_atd_rx_controller
// Self-checking bench for atd_rx_controller. Expected bytes are queued when a
// frame that should be accepted is driven and popped when the consumer takes
// the byte from the DUT.
// -----------------------------------------------------------------------------
module tb_atd_rx_controller;

  localparam int NB = 8;
  localparam int TO = 255;

  logic          tb_clk = 1'b0;
  logic          n_rst;
  logic          ATD_shift_enable;
  logic          ATD_data;
  logic          rx_ready;
  logic          clear_errors;
  logic [NB-1:0] rx_data;
  logic          rx_valid;
  logic          busy;
  logic          framing_error;
  logic          timeout_error;
  logic          overrun_error;

  int total = 0;
  int bad   = 0;

  logic [NB-1:0] exp_q[$];
  logic [NB-1:0] exp_b;

  atd_rx_controller #(
    .NUM_DATA_BITS  (NB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk              (tb_clk),
    .n_rst            (n_rst),
    .ATD_shift_enable (ATD_shift_enable),
    .ATD_data         (ATD_data),
    .rx_ready         (rx_ready),
    .clear_errors     (clear_errors),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .busy             (busy),
    .framing_error    (framing_error),
    .timeout_error    (timeout_error),
    .overrun_error    (overrun_error)
  );

  always #5 tb_clk = ~tb_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- helpers
  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send_bit(input logic b);
    ATD_shift_enable = 1'b1;
    ATD_data         = b;
    step();
    ATD_shift_enable = 1'b0;
    ATD_data         = 1'b1;
  endtask

  // Returns just after the clock edge that samples the stop bit.
  task automatic send_frame(input logic [NB-1:0] d, input logic stop_bit,
                            input int gap, input logic rdy_at_stop,
                            input logic clr_at_stop);
    send_bit(1'b0);
    idle(gap - 1);
    for (int i = NB - 1; i >= 0; i--) begin
      send_bit(d[i]);
      idle(gap - 1);
    end
    rx_ready     = rdy_at_stop;
    clear_errors = clr_at_stop;
    send_bit(stop_bit);
    rx_ready     = 1'b0;
    clear_errors = 1'b0;
  endtask

  task automatic ready_pulse();
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
  endtask

  function automatic logic [NB-1:0] pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  function automatic logic [NB-1:0] peek_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q[0];
  endfunction

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    n_rst = 1'b0;
    idle(2);
    total++;
    if ({rx_valid, busy, framing_error, timeout_error, overrun_error} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b expected 00000",
               {rx_valid, busy, framing_error, timeout_error, overrun_error});
    end
    total++;
    if (rx_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_data: got %h expected 00", rx_data);
    end
    @(negedge tb_clk);
    n_rst = 1'b1;
    step();

    // Fill the buffer, then reset in the middle of the next frame.
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 4, 1'b0, 1'b0);
    total++;
    if (rx_valid !== 1'b1 || rx_data !== peek_exp()) begin
      bad++;
      $display("FAIL pre_reset_byte: got valid=%b data=%h expected valid=1 data=%h",
               rx_valid, rx_data, peek_exp());
    end
    send_bit(1'b0);
    idle(3);
    send_bit(1'b1);
    send_bit(1'b0);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_mid_frame: got %b expected 1", busy);
    end
    #2 n_rst = 1'b0;
    #1;
    exp_b = pop_exp();  // buffered byte is lost by reset
    total++;
    if ({rx_valid, busy, framing_error, timeout_error, overrun_error} !== 5'b0
        || rx_data !== 8'h00) begin
      bad++;
      $display("FAIL async_reset: got flags=%b data=%h expected flags=00000 data=00",
               {rx_valid, busy, framing_error, timeout_error, overrun_error}, rx_data);
    end
    @(negedge tb_clk);
    n_rst = 1'b1;
    step();

    exp_q.push_back(8'hE7);
    send_frame(8'hE7, 1'b1, 5, 1'b0, 1'b0);
    exp_b = pop_exp();
    total++;
    if (rx_valid !== 1'b1 || rx_data !== exp_b || busy !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_frame: got valid=%b data=%h busy=%b expected valid=1 data=%h busy=0",
               rx_valid, rx_data, busy, exp_b);
    end
    ready_pulse();
    total++;
    if (rx_valid !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_consume: got valid=%b expected 0", rx_valid);
    end
  endtask

  task automatic test_basic_frame();
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 10, 1'b0, 1'b0);
    total++;
    if (rx_valid !== 1'b1 || rx_data !== peek_exp() || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_first_cycle: got valid=%b data=%h busy=%b expected valid=1 data=%h busy=0",
               rx_valid, rx_data, busy, peek_exp());
    end
    for (int i = 0; i < 12; i++) begin
      step();
      total++;
      if (rx_valid !== 1'b1 || rx_data !== peek_exp()) begin
        bad++;
        $display("FAIL basic_hold[%0d]: got valid=%b data=%h expected valid=1 data=%h",
                 i, rx_valid, rx_data, peek_exp());
      end
    end
    exp_b = pop_exp();
    total++;
    if (rx_data !== exp_b) begin
      bad++;
      $display("FAIL basic_consume_data: got %h expected %h", rx_data, exp_b);
    end
    ready_pulse();
    total++;
    if (rx_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_valid_drop: got %b expected 0", rx_valid);
    end
    // Ready with nothing buffered changes nothing.
    ready_pulse();
    step();
    total++;
    if (rx_valid !== 1'b0 || rx_data !== exp_b) begin
      bad++;
      $display("FAIL idle_ready: got valid=%b data=%h expected valid=0 data=%h",
               rx_valid, rx_data, exp_b);
    end
  endtask

  task automatic test_framing_error();
    send_frame(8'hA5, 1'b0, 10, 1'b0, 1'b0);
    total++;
    if ({framing_error, rx_valid, busy} !== 3'b100) begin
      bad++;
      $display("FAIL framing_pulse: got fe/valid/busy=%b expected 100",
               {framing_error, rx_valid, busy});
    end
    step();
    total++;
    if ({framing_error, rx_valid, busy} !== 3'b000) begin
      bad++;
      $display("FAIL framing_one_cycle: got fe/valid/busy=%b expected 000",
               {framing_error, rx_valid, busy});
    end
  endtask

  task automatic test_timeout();
    int hits;
    int at;
    hits = 0;
    at   = -1;
    send_bit(1'b0);
    idle(9);
    for (int i = 0; i < 3; i++) begin
      send_bit(1'b1);
      if (i < 2) idle(9);
    end
    for (int k = 1; k <= 300; k++) begin
      step();
      if (timeout_error === 1'b1) begin
        hits++;
        if (at < 0) at = k;
      end
    end
    total++;
    if (hits !== 1 || at !== TO) begin
      bad++;
      $display("FAIL timeout_pulse: got hits=%0d at=%0d expected hits=1 at=%0d",
               hits, at, TO);
    end
    total++;
    if (busy !== 1'b0 || rx_valid !== 1'b0) begin
      bad++;
      $display("FAIL timeout_idle: got busy=%b valid=%b expected 0 0", busy, rx_valid);
    end
  endtask

  task automatic test_pulse_at_timeout();
    logic [NB-1:0] d;
    d = 8'h81;
    exp_q.push_back(d);
    send_bit(1'b0);
    idle(TO - 1);
    send_bit(d[NB-1]);  // lands on the cycle the timer would expire
    total++;
    if (timeout_error !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL pulse_beats_timeout: got to=%b busy=%b expected 0 1",
               timeout_error, busy);
    end
    for (int i = NB - 2; i >= 0; i--) begin
      idle(9);
      send_bit(d[i]);
    end
    idle(9);
    send_bit(1'b1);
    exp_b = pop_exp();
    total++;
    if (rx_valid !== 1'b1 || rx_data !== exp_b) begin
      bad++;
      $display("FAIL pulse_timeout_frame: got valid=%b data=%h expected valid=1 data=%h",
               rx_valid, rx_data, exp_b);
    end
    ready_pulse();
  endtask

  task automatic test_overrun();
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 10, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b1, 10, 1'b0, 1'b0);  // dropped
    total++;
    if (overrun_error !== 1'b1 || rx_valid !== 1'b1 || rx_data !== peek_exp()) begin
      bad++;
      $display("FAIL overrun_set: got ovr=%b valid=%b data=%h expected 1 1 %h",
               overrun_error, rx_valid, rx_data, peek_exp());
    end
    clear_errors = 1'b1;
    step();
    clear_errors = 1'b0;
    total++;
    if (overrun_error !== 1'b0) begin
      bad++;
      $display("FAIL overrun_clear: got %b expected 0", overrun_error);
    end
    send_frame(8'h11, 1'b1, 10, 1'b0, 1'b1);  // clear coincides with overrun
    total++;
    if (overrun_error !== 1'b1 || rx_data !== peek_exp()) begin
      bad++;
      $display("FAIL overrun_priority: got ovr=%b data=%h expected 1 %h",
               overrun_error, rx_data, peek_exp());
    end
    clear_errors = 1'b1;
    step();
    clear_errors = 1'b0;
    exp_b = pop_exp();
    total++;
    if (overrun_error !== 1'b0 || rx_data !== exp_b) begin
      bad++;
      $display("FAIL overrun_reclear: got ovr=%b data=%h expected 0 %h",
               overrun_error, rx_data, exp_b);
    end
    ready_pulse();
    total++;
    if (rx_valid !== 1'b0) begin
      bad++;
      $display("FAIL overrun_consume: got valid=%b expected 0", rx_valid);
    end
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 10, 1'b0, 1'b0);
    exp_b = pop_exp();  // taken by rx_ready on the next frame's stop edge
    total++;
    if (rx_valid !== 1'b1 || rx_data !== exp_b) begin
      bad++;
      $display("FAIL b2b_first: got valid=%b data=%h expected valid=1 data=%h",
               rx_valid, rx_data, exp_b);
    end
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 10, 1'b1, 1'b0);
    exp_b = pop_exp();
    total++;
    if (rx_valid !== 1'b1 || rx_data !== exp_b || overrun_error !== 1'b0) begin
      bad++;
      $display("FAIL b2b_replace: got valid=%b data=%h ovr=%b expected valid=1 data=%h ovr=0",
               rx_valid, rx_data, overrun_error, exp_b);
    end
    ready_pulse();
    total++;
    if (rx_valid !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL b2b_drain: got valid=%b queued=%0d expected valid=0 queued=0",
               rx_valid, exp_q.size());
    end
  endtask

  initial begin
    n_rst            = 1'b0;
    ATD_shift_enable = 1'b0;
    ATD_data         = 1'b1;
    rx_ready         = 1'b0;
    clear_errors     = 1'b0;

    test_reset();
    test_basic_frame();
    test_framing_error();
    test_timeout();
    test_pulse_at_timeout();
    test_overrun();
    test_back_to_back();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/atd_rx_controller.md
ATD_RX_CONTROLLER -- requirements
Module: atd_rx_controller

Interface
REQ-001 The block SHALL have parameter NUM_DATA_BITS, default 8, data bits per ATD frame.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 255, the maximum clk cycles between shift pulses inside a frame.
REQ-003 Port clk  input  1  the single system clock; all logic is on its rising edge.
REQ-004 Port n_rst  input  1  reset; asynchronous, active-low.
REQ-005 Port ATD_shift_enable  input  1  one-cycle pulse from atd_detector marking an ATD_clk rising edge.
REQ-006 Port ATD_data  input  1  serial data, already synchronized; idle level high.
REQ-007 Port rx_ready  input  1  consumer accepts rx_data this cycle.
REQ-008 Port clear_errors  input  1  clears sticky overrun_error.
REQ-009 Port rx_data  output  NUM_DATA_BITS  received byte, MSB first on the wire.
REQ-010 Port rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-011 Port busy  output  1  high in any state other than IDLE.
REQ-012 Port framing_error  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-013 Port timeout_error  output  1  one-cycle pulse on an intra-frame timeout.
REQ-014 Port overrun_error  output  1  sticky; a frame completed while the buffer was full.

Function
REQ-015 Frame format SHALL be one start bit (0), NUM_DATA_BITS data bits MSB first, then one stop bit (1), each sampled only in cycles where ATD_shift_enable=1.
REQ-016 FSM states SHALL be IDLE, DATA and STOP.
REQ-017 IDLE: shift pulse with ATD_data=0 -> DATA, with bit counter=0 and timer=0; shift pulse with ATD_data=1 is ignored.
REQ-018 DATA: each shift pulse SHALL shift ATD_data into the LSB of the shift register and increment the bit counter; the pulse sampling bit NUM_DATA_BITS -> STOP.
REQ-019 STOP, shift pulse with ATD_data=1: the shift register SHALL load into rx_data, with rx_valid=1 from the next cycle; -> IDLE.
REQ-020 STOP, shift pulse with ATD_data=0: framing_error SHALL pulse for exactly one cycle (the next cycle); the byte is discarded; -> IDLE.
REQ-021 The timer SHALL clear on every shift pulse and increment each cycle in DATA/STOP; when it reaches TIMEOUT_CYCLES with no pulse, timeout_error SHALL pulse once, the partial frame is discarded, -> IDLE.
REQ-022 rx_valid SHALL stay high, with rx_data stable, until a cycle with rx_ready=1; rx_valid SHALL then fall on the next edge.
REQ-023 rx_ready while rx_valid=0 SHALL have no effect.
REQ-024 Stop-bit completion while rx_valid=1 and rx_ready=0: the old byte SHALL be kept, the new byte dropped, and overrun_error set.
REQ-025 Completion in the same cycle as rx_ready=1 with rx_valid=1: the new byte SHALL replace the old, rx_valid stays 1, and no overrun occurs.
REQ-026 clear_errors=1 SHALL clear overrun_error next cycle; a simultaneous overrun event SHALL take priority (flag stays set).
REQ-027 A shift pulse in the same cycle as a timeout SHALL take priority (the bit is sampled, no timeout).
REQ-028 Output latency: every output SHALL be registered, changing one cycle after the causing input.

Reset
REQ-029 n_rst=0 SHALL asynchronously force state IDLE, the shift register, bit counter, timer and rx_data to 0, and rx_valid, busy, framing_error, timeout_error and overrun_error to 0.
REQ-030 Reset mid-frame SHALL discard the partial frame; after release, the block SHALL wait in IDLE for a new start bit.

Structure
REQ-031 Package atd_pkg SHALL hold the state enum type and default constants NUM_DATA_BITS and TIMEOUT_CYCLES.
REQ-032 The timer SHALL be a sub-module named flex_counter (parameter NUM_CNT_BITS=8, with clear, count_enable and rollover_val inputs and a rollover_flag output); everything else is in atd_rx_controller.

Verification
REQ-033 Reset: n_rst=0 mid-DATA -> all outputs 0 and busy=0 immediately; the next frame receives correctly.
REQ-034 Frame 0,1010_0101,1 with pulses every 10 cycles and rx_ready=0 -> rx_valid=1 and rx_data=0xA5 one cycle after the stop pulse, held until rx_ready=1 for one cycle, then rx_valid=0.
REQ-035 Frame 0xA5 with stop bit 0 -> framing_error high for exactly 1 cycle, rx_valid stays 0, busy=0.
REQ-036 Start bit followed by 3 data pulses, then no pulses for 300 cycles -> timeout_error pulses once, 255 cycles after the last pulse; busy=0.
REQ-037 Two frames 0x3C then 0xC3 with rx_ready=0 -> rx_data=0x3C and overrun_error=1; clear_errors -> overrun_error=0.
REQ-038 Second frame completes in the same cycle as rx_ready=1 -> rx_data=0xC3, rx_valid stays 1, overrun_error=0.
